// File: rtl/fft_ctrl_pkg.sv
// Shared types for the FFT engine control path: sequencer states and twiddle selection.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } bseq_state_t;

  // Decoded by the butterfly: TW_ONE multiplies by 1, TW_NEG_J by -j.
  typedef enum logic {
    TW_ONE   = 1'b0,
    TW_NEG_J = 1'b1
  } tw_sel_t;

endpackage

// File: rtl/fft_dly_line.sv
// Fixed-depth shift register used to align write strobes with the datapath latency.
module fft_dly_line #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  // Shift every cycle; reset and flush empty all stages at once.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_bfly_seq.sv
// Butterfly issue sequencer: NUM_STAGES passes of BLK_LEN issues, each followed by
// a LAT-cycle drain gap so in-place writes land before the next stage reads.
module fft_bfly_seq
  import fft_ctrl_pkg::*;
#(
  parameter  int unsigned BLK_LEN    = 16,
  parameter  int unsigned NUM_STAGES = 4,
  parameter  int unsigned LAT        = 2,
  localparam int unsigned AW         = $clog2(BLK_LEN),
  localparam int unsigned SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          bfly_en,
  output tw_sel_t       tw_sel,
  output logic [AW-1:0] rd_addr,
  output logic [SW-1:0] stage_idx,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr
);

  localparam int unsigned GW = (LAT > 1) ? $clog2(LAT) : 1;

  bseq_state_t   state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_inc;
  logic [SW-1:0] stage;
  logic [GW-1:0] gap_cnt;
  logic [AW:0]   dly_q;

  assign cnt_inc = cnt + AW'(1);

  // Sequencer state, counters and registered issue-side outputs.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state   <= IDLE;
      cnt     <= '0;
      stage   <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bfly_en <= 1'b0;
      tw_sel  <= TW_ONE;
    end else begin
      done    <= 1'b0;
      bfly_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            stage   <= '0;
            busy    <= 1'b1;
            bfly_en <= 1'b1;
            tw_sel  <= TW_ONE;
          end
        end
        RUN: begin
          // A held edge freezes the address and suppresses the next issue strobe.
          if (!hold) begin
            if (cnt == AW'(BLK_LEN - 1)) begin
              state   <= GAP;
              cnt     <= '0;
              gap_cnt <= '0;
              tw_sel  <= TW_ONE;
            end else begin
              cnt     <= cnt_inc;
              bfly_en <= 1'b1;
              tw_sel  <= cnt_inc[AW-1] ? TW_NEG_J : TW_ONE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(LAT - 1)) begin
            gap_cnt <= '0;
            if (stage == SW'(NUM_STAGES - 1)) begin
              state <= DONE;
              stage <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              stage   <= stage + SW'(1);
              bfly_en <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr   = cnt;
  assign stage_idx = stage;

  // Write side trails the issue side by the butterfly latency; abort drops in-flight writes.
  fft_dly_line #(
    .W     (1 + AW),
    .DEPTH (LAT)
  ) u_wr_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .d     ({bfly_en, rd_addr}),
    .q     (dly_q)
  );

  assign {wr_en, wr_addr} = dly_q;

endmodule

// File: tb/tb_fft_bfly_seq.sv
// Testbench for fft_bfly_seq: default-parameter instance plus a minimum-size instance.
module tb_fft_bfly_seq;
  import fft_ctrl_pkg::*;

  localparam int BLK  = 16;
  localparam int NST  = 4;
  localparam int LATM = 2;

  logic clk = 1'b0;
  logic rst, start, hold, abort;
  logic busy, done, bfly_en, wr_en;
  tw_sel_t tw_sel;
  logic [3:0] rd_addr, wr_addr;
  logic [1:0] stage_idx;

  logic e_start, e_hold, e_abort;
  logic e_busy, e_done, e_bfly_en, e_wr_en;
  tw_sel_t e_tw_sel;
  logic [0:0] e_rd_addr, e_wr_addr, e_stage_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_bfly_seq #(.BLK_LEN(BLK), .NUM_STAGES(NST), .LAT(LATM)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
    .busy(busy), .done(done), .bfly_en(bfly_en), .tw_sel(tw_sel),
    .rd_addr(rd_addr), .stage_idx(stage_idx), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  fft_bfly_seq #(.BLK_LEN(2), .NUM_STAGES(1), .LAT(1)) dut_edge (
    .clk(clk), .rst(rst), .start(e_start), .hold(e_hold), .abort(e_abort),
    .busy(e_busy), .done(e_done), .bfly_en(e_bfly_en), .tw_sel(e_tw_sel),
    .rd_addr(e_rd_addr), .stage_idx(e_stage_idx), .wr_en(e_wr_en), .wr_addr(e_wr_addr)
  );

  // One frame scenario; -1 disables a field, exp_done 0 means no done pulse expected.
  typedef struct packed {
    int hold_rel;
    int hold_len;
    int chk_hold;
    int hold_addr;
    int abort_rel;
    int junk0;
    int junk1;
    int junk2;
    int exp_done;
    int exp_busy;
    int n_issue;
    int n_write;
    int run_len;
  } vec_t;

  localparam int NV = 6;
  vec_t  vecs [NV];
  string vnames [NV];

  logic [6:0] iq [$];
  logic [3:0] wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] main_outs();
    return 32'({busy, done, bfly_en, tw_sel, rd_addr, stage_idx, wr_en, wr_addr});
  endfunction

  function automatic logic [31:0] edge_outs();
    return 32'({e_busy, e_done, e_bfly_en, e_tw_sel, e_rd_addr, e_stage_idx, e_wr_en, e_wr_addr});
  endfunction

  // Apply one table scenario starting from IDLE; scoreboard checks every issue and write.
  task automatic run_frame(input int vi);
    vec_t v;
    int busy_cnt, done_rel, done_cnt, first_bf, first_wr, np;
    logic [6:0] ei;
    logic [3:0] ew;
    v = vecs[vi];
    busy_cnt = 0; done_rel = 0; done_cnt = 0; first_bf = -1; first_wr = -1;
    iq.delete();
    wq.delete();
    np = 0;
    for (int s = 0; s < NST; s++)
      for (int c = 0; c < BLK; c++) begin
        if (np < v.n_issue) iq.push_back({2'(s), 4'(c), (c >= BLK/2)});
        if (np < v.n_write) wq.push_back(4'(c));
        np++;
      end
    start = 1'b1;
    for (int rel = 1; rel <= v.run_len; rel++) begin
      tick();
      start = 1'b0;
      hold  = 1'b0;
      abort = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_rel = rel; end
      if (bfly_en) begin
        if (first_bf < 0) first_bf = rel;
        if (iq.size() == 0) chk({vnames[vi], "_issue_extra"}, 32'(rel), 32'(0));
        else begin
          ei = iq.pop_front();
          chk({vnames[vi], "_issue"}, 32'({stage_idx, rd_addr, tw_sel}), 32'(ei));
        end
      end
      if (wr_en) begin
        if (first_wr < 0) first_wr = rel;
        if (wq.size() == 0) chk({vnames[vi], "_write_extra"}, 32'(rel), 32'(0));
        else begin
          ew = wq.pop_front();
          chk({vnames[vi], "_wr_addr"}, 32'(wr_addr), 32'(ew));
        end
      end
      if (v.chk_hold != 0 && rel > v.hold_rel && rel <= v.hold_rel + v.hold_len) begin
        chk({vnames[vi], "_hold_addr"}, 32'(rd_addr), 32'(v.hold_addr));
        chk({vnames[vi], "_hold_bfly"}, 32'(bfly_en), 32'(0));
      end
      if (rel == v.abort_rel + 1)
        chk({vnames[vi], "_post_abort"}, 32'({busy, bfly_en, wr_en, stage_idx}), 32'(0));
      if (rel >= v.hold_rel && rel < v.hold_rel + v.hold_len) hold = 1'b1;
      if (rel == v.abort_rel) abort = 1'b1;
      if (rel == v.junk0 || rel == v.junk1 || rel == v.junk2) start = 1'b1;
    end
    chk({vnames[vi], "_busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
    chk({vnames[vi], "_done_rel"}, 32'(done_rel), 32'(v.exp_done));
    chk({vnames[vi], "_done_pulses"}, 32'(done_cnt), 32'((v.exp_done != 0) ? 1 : 0));
    chk({vnames[vi], "_first_bfly"}, 32'(first_bf), 32'(1));
    chk({vnames[vi], "_first_wr"}, 32'(first_wr), 32'(1 + LATM));
    chk({vnames[vi], "_issue_left"}, 32'(iq.size()), 32'(0));
    chk({vnames[vi], "_write_left"}, 32'(wq.size()), 32'(0));
  endtask

  initial begin
    int rel, dcnt, d1, d2;
    //                 hold_rel len chk addr abort junk0 junk1 junk2 done busy iss wr  run
    vecs[0] = '{-1, 0, 0, 0, -1, -1, -1, -1, 73, 72, 64, 64, 80};  vnames[0] = "nominal";
    vecs[1] = '{24, 3, 1, 5, -1, -1, -1, -1, 76, 75, 64, 64, 82};  vnames[1] = "hold_s1c5";
    vecs[2] = '{-1, 0, 0, 0, 46, -1, -1, -1,  0, 46, 42, 40, 80};  vnames[2] = "abort_s2c9";
    vecs[3] = '{-1, 0, 0, 0, -1, -1, -1, -1, 73, 72, 64, 64, 80};  vnames[3] = "after_abort";
    vecs[4] = '{-1, 0, 0, 0, -1, 10, 17, 73, 73, 72, 64, 64, 80};  vnames[4] = "junk_start";
    vecs[5] = '{17, 2, 0, 0, -1, -1, -1, -1, 73, 72, 64, 64, 80};  vnames[5] = "hold_in_gap";

    rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
    e_start = 1'b0; e_hold = 1'b0; e_abort = 1'b0;
    repeat (2) tick();
    chk("reset_main_outs", main_outs(), 32'(0));
    chk("reset_edge_outs", edge_outs(), 32'(0));
    rst = 1'b0;
    tick();
    chk("post_reset_main_outs", main_outs(), 32'(0));

    // Reset held three cycles in the middle of stage 0, then an immediate restart.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_seq_run", 32'({busy, bfly_en}), 32'(3));
    repeat (9) tick();
    rst = 1'b1;
    for (int r = 11; r <= 13; r++) begin
      tick();
      chk("rst_mid_run_outs", main_outs(), 32'(0));
    end
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_restart", 32'({busy, bfly_en, rd_addr, stage_idx}), 32'({1'b1, 1'b1, 4'd0, 2'd0}));
    rel = 14;
    while (!done && rel < 200) begin
      tick();
      rel++;
    end
    chk("rst_restart_done_rel", 32'(rel), 32'(86));
    tick();

    // Minimum-size instance: two issues, one gap cycle, done on the 4th cycle.
    e_start = 1'b1;
    tick();
    e_start = 1'b0;
    chk("edge_c1", 32'({e_busy, e_bfly_en, e_tw_sel, e_rd_addr, e_wr_en, e_done}), 32'(6'b110000));
    tick();
    chk("edge_c2", 32'({e_busy, e_bfly_en, e_tw_sel, e_rd_addr, e_wr_en, e_wr_addr, e_done}), 32'(7'b1111100));
    tick();
    chk("edge_c3", 32'({e_busy, e_bfly_en, e_wr_en, e_wr_addr, e_done}), 32'(5'b10110));
    tick();
    chk("edge_c4", 32'({e_busy, e_bfly_en, e_wr_en, e_done}), 32'(4'b0001));
    tick();
    chk("edge_c5", edge_outs(), 32'(0));

    for (int i = 0; i < NV; i++) run_frame(i);

    // Start held high: back-to-back frames with one IDLE cycle after each done.
    start = 1'b1;
    dcnt = 0; d1 = 0; d2 = 0;
    for (int r = 1; r <= 150; r++) begin
      tick();
      if (done) begin
        dcnt++;
        if (dcnt == 1) d1 = r;
        if (dcnt == 2) d2 = r;
      end
      if (r == 74) chk("held_idle_gap", 32'({busy, bfly_en}), 32'(0));
      if (r == 75) chk("held_restart", 32'({busy, bfly_en, rd_addr, stage_idx}), 32'({1'b1, 1'b1, 4'd0, 2'd0}));
    end
    chk("held_done_count", 32'(dcnt), 32'(2));
    chk("held_done1_rel", 32'(d1), 32'(73));
    chk("held_done2_rel", 32'(d2), 32'(147));
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("held_abort_idle", 32'({busy, bfly_en, wr_en, done}), 32'(0));
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
